// File: rtl/data_mem_resp.sv
// data_mem_resp: wait-stated data memory with byte/half/word loads and stores (DMEM_MISALIGN_ERR_EN enables misalign errors)
module data_mem_resp #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 9,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic              rd,
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              resp_valid,
   output logic              busy,
   output logic              err
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [3:0] LAST = 4'(WAIT_STATES - 1);
   state_t state;
   logic [3:0] cnt;
   logic [ADDR_W-1:0] q_addr, a;
   logic [2:0] q_funct3, f;
   logic [DATA_W-1:0] q_wr_data;
   logic q_wr;
   logic [DATA_W-1:0] mem [2**(ADDR_W-2)];
   logic is_b, is_h, is_wr, bad;
   logic [1:0] off;
   logic [DATA_W-1:0] word, sh, ld, mask, wsh, resp_data;
   // in IDLE the live request is decoded so a zero-wait response can be registered on the acceptance edge
   assign a = (state == IDLE) ? addr : q_addr;
   assign f = (state == IDLE) ? funct3 : q_funct3;
   assign is_wr = (state == IDLE) ? wr : q_wr;
   assign is_b = f[1:0] == 2'b00;
   assign is_h = f[1:0] == 2'b01;
   // misaligned low bits are dropped; when errors are enabled the access is suppressed anyway
   assign off = is_b ? a[1:0] : is_h ? {a[1], 1'b0} : 2'b00;
   assign word = mem[a[ADDR_W-1:2]];
   assign sh = word >> {off, 3'b000};
   assign ld = is_b ? {{(DATA_W-8){~f[2] & sh[7]}}, sh[7:0]}
             : is_h ? {{(DATA_W-16){~f[2] & sh[15]}}, sh[15:0]} : sh;
   assign mask = (is_b ? DATA_W'(8'hFF) : is_h ? DATA_W'(16'hFFFF) : {DATA_W{1'b1}}) << {off, 3'b000};
   assign wsh = q_wr_data << {off, 3'b000};
`ifdef DMEM_MISALIGN_ERR_EN
   assign bad = is_h ? a[0] : !is_b && a[1:0] != 2'b00;
`else
   assign bad = 1'b0;
`endif
   assign resp_data = (is_wr || bad) ? '0 : ld;
   // commit store lanes on the edge leaving RESP; contents survive reset
   always_ff @(posedge clk)
      if (!reset && state == RESP && q_wr && !bad) mem[a[ADDR_W-1:2]] <= (word & ~mask) | (wsh & mask);
   // request sequencing with registered response outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         busy <= 1'b0;
         resp_valid <= 1'b0;
         err <= 1'b0;
         rd_data <= '0;
      end else begin
         resp_valid <= 1'b0;
         err <= 1'b0;
         rd_data <= '0;
         case (state)
            IDLE: if (wr || rd) begin
               q_addr <= addr;
               q_funct3 <= funct3;
               q_wr_data <= wr_data;
               q_wr <= wr;
               cnt <= '0;
               busy <= 1'b1;
               if (WAIT_STATES == 0) begin
                  state <= RESP;
                  resp_valid <= 1'b1;
                  err <= bad;
                  rd_data <= resp_data;
               end else state <= WAIT;
            end
            WAIT: if (cnt == LAST) begin
               state <= RESP;
               resp_valid <= 1'b1;
               err <= bad;
               rd_data <= resp_data;
            end else cnt <= cnt + 4'd1;
            default: begin
               state <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: vector table, corner sequences and random traffic against a byte-array memory model
module tb_data_mem_resp;
   localparam int WS = 1;
   logic clk = 1'b0, reset = 1'b1, wr = 1'b0, rd = 1'b0;
   logic [8:0] addr = '0;
   logic [2:0] funct3 = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic resp_valid, busy, err;
   int total = 0, bad = 0;
   logic [7:0] m [512];
   typedef struct {
      logic w, r;
      logic [8:0] a;
      logic [2:0] f;
      logic [31:0] d, q;
      logic e;
   } vec_t;
   vec_t tbl [16];
   logic [2:0] fsel [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
`ifdef DMEM_MISALIGN_ERR_EN
   localparam logic MIS_E = 1'b1;
   localparam logic [31:0] MIS_V = 32'h11223344;
`else
   localparam logic MIS_E = 1'b0;
   localparam logic [31:0] MIS_V = 32'h99AABBCC;
`endif

   always #5 clk = ~clk;

   data_mem_resp #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .funct3(funct3),
      .wr_data(wr_data), .rd_data(rd_data), .resp_valid(resp_valid), .busy(busy), .err(err)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic void model(input logic w, input logic [8:0] a, input logic [2:0] f,
                                 input logic [31:0] d, output logic [31:0] q, output logic e);
      int n, base;
      logic [31:0] v;
      n = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
      base = int'(a) - int'(a) % n;
      q = '0;
      e = 1'b0;
      v = '0;
`ifdef DMEM_MISALIGN_ERR_EN
      if (int'(a) % n != 0) begin
         e = 1'b1;
         return;
      end
`endif
      if (w) for (int i = 0; i < n; i++) m[base + i] = d[8*i +: 8];
      else begin
         for (int i = 0; i < n; i++) v[8*i +: 8] = m[base + i];
         if (n < 4 && !f[2] && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
         q = v;
      end
   endfunction

   // latency counts the acceptance cycle as cycle 1, so a response WS cycles later is WS+1
   task automatic run(input string name, input logic w, input logic r, input logic [8:0] a, input logic [2:0] f,
                      input logic [31:0] d, input logic [31:0] exp_q, input logic exp_e);
      int lat;
      @(negedge clk);
      wr = w; rd = r; addr = a; funct3 = f; wr_data = d;
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, " lat"}, 32'(lat), 32'(WS + 1));
      check({name, " data"}, rd_data, exp_q);
      check({name, " err"}, 32'(err), 32'(exp_e));
      @(posedge clk); #1;
      check({name, " idle"}, {30'd0, resp_valid, busy}, 32'd0);
   endtask

   task automatic txn(input string name, input logic w, input logic r, input logic [8:0] a,
                      input logic [2:0] f, input logic [31:0] d);
      logic [31:0] q;
      logic e;
      model(w, a, f, d, q, e);
      run(name, w, r, a, f, d, q, e);
   endtask

   initial begin
      logic [31:0] q, got;
      logic e, w;
      int n;
      tbl[0]  = '{1'b1, 1'b0, 9'h010, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 9'h010, 3'b010, 32'h0, 32'h0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 9'h013, 3'b000, 32'h80, 32'h0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 9'h013, 3'b000, 32'h0, 32'hFFFFFF80, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 9'h013, 3'b100, 32'h0, 32'h00000080, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 32'h80000000, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 9'h020, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 9'h022, 3'b001, 32'h00001234, 32'h0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 9'h020, 3'b010, 32'h0, 32'h1234F00D, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 9'h020, 3'b001, 32'h0, 32'hFFFFF00D, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 9'h020, 3'b101, 32'h0, 32'h0000F00D, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 9'h024, 3'b010, 32'hA5A5A5A5, 32'h0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 9'h024, 3'b010, 32'h0, 32'hA5A5A5A5, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 9'h020, 3'b111, 32'h0, 32'h1234F00D, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 9'h022, 3'b100, 32'h0, 32'h00000034, 1'b0};
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset out", {rd_data[31:3], err, resp_valid, busy}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 128; i++) txn("init", 1'b1, 1'b0, 9'(4 * i), 3'b010, $urandom);
      for (int i = 0; i < 16; i++) begin
         model(tbl[i].w, tbl[i].a, tbl[i].f, tbl[i].d, q, e);
         run($sformatf("vec%0d", i), tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].f, tbl[i].d, tbl[i].q, tbl[i].e);
      end
      model(1'b0, 9'h010, 3'b010, 32'h0, q, e);
      @(negedge clk);
      rd = 1'b1; addr = 9'h010; funct3 = 3'b010;
      @(posedge clk); #1;
      rd = 1'b0;
      @(negedge clk);
      rd = 1'b1; addr = 9'h020;
      n = 0;
      got = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            n++;
            if (n == 1) got = rd_data;
         end
         rd = 1'b0;
      end
      check("busy ignore count", 32'(n), 32'd1);
      check("busy ignore data", got, q);
      run("mis pre", 1'b1, 1'b0, 9'h030, 3'b010, 32'h11223344, 32'h0, 1'b0);
      model(1'b1, 9'h030, 3'b010, 32'h11223344, q, e);
      run("mis st", 1'b1, 1'b0, 9'h031, 3'b010, 32'h99AABBCC, 32'h0, MIS_E);
      model(1'b1, 9'h031, 3'b010, 32'h99AABBCC, q, e);
      run("mis ld", 1'b0, 1'b1, 9'h030, 3'b010, 32'h0, MIS_V, 1'b0);
      @(negedge clk);
      wr = 1'b1; addr = 9'h030; funct3 = 3'b000; wr_data = 32'h55;
      @(posedge clk); #1;
      wr = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      check("rst abort", {rd_data[31:3], err, resp_valid, busy}, 32'd0);
      reset = 1'b0;
      txn("rst load", 1'b0, 1'b1, 9'h030, 3'b100, 32'h0);
      txn("rst load w", 1'b0, 1'b1, 9'h030, 3'b010, 32'h0);
      for (int i = 0; i < 300; i++) begin
         w = 1'($urandom_range(0, 1));
         txn("rand", w, !w || ($urandom_range(0, 3) == 0), 9'($urandom_range(0, 511)),
             fsel[$urandom_range(0, 7)], $urandom);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
